// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg
//   Shared definitions for the serial instruction-memory loader:
//   - width constants for bytes, instruction words and the frame length field
//   - default instruction-memory depth
//   - loader FSM state encoding
package imem_loader_pkg;

  localparam int BYTE_W              = 8;
  localparam int WORD_W              = 32;
  localparam int LEN_W               = 16;
  localparam int DEFAULT_DEPTH_WORDS = 64;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_LO = 3'd1,
    ST_LEN_HI = 3'd2,
    ST_DATA   = 3'd3,
    ST_WRITE  = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERR    = 3'd6
  } state_t;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// byte_packer
//   Assembles four serial bytes into one little-endian 32-bit word.
//   Ports:
//     clk          - clock
//     reset        - synchronous active-high reset
//     i_clear      - restart assembly (new load)
//     i_byte_en    - accept i_byte this cycle
//     i_byte       - incoming byte
//     o_word       - assembled word register
//     o_word_ready - high on the cycle the fourth byte of a word is accepted
module byte_packer
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              i_clear,
  input  logic              i_byte_en,
  input  logic [BYTE_W-1:0] i_byte,
  output logic [WORD_W-1:0] o_word,
  output logic              o_word_ready
);

  logic [1:0]        r_cnt;
  logic [WORD_W-1:0] r_word;

  // Shifting in from the top leaves the first byte in [7:0] after four bytes.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt  <= '0;
      r_word <= '0;
    end else if (i_clear) begin
      r_cnt  <= '0;
      r_word <= '0;
    end else if (i_byte_en) begin
      r_cnt  <= r_cnt + 2'd1;
      r_word <= {i_byte, r_word[WORD_W-1:BYTE_W]};
    end
  end

  assign o_word       = r_word;
  assign o_word_ready = i_byte_en && (r_cnt == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// imem_loader
//   Receives a length-prefixed byte stream and writes it into instruction
//   memory, holding the CPU in reset until a load completes.
//   Frame: 16-bit little-endian word count N, then N*4 little-endian bytes.
//   Ports:
//     clk, reset               - clock, synchronous active-high reset
//     start                    - begin a load (honoured in IDLE/DONE/ERR)
//     byte_in/valid/ready      - serial byte stream handshake
//     imem_we/addr/wdata       - one-cycle instruction-memory write
//     cpu_reset                - low only after a successful load
//     busy, done, error        - loader status
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int          DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [BYTE_W-1:0] byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              imem_we,
  output logic [WORD_W-1:0] imem_addr,
  output logic [WORD_W-1:0] imem_wdata,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              error
);

  state_t             r_state;
  state_t             w_state_next;
  logic [LEN_W-1:0]   r_idx;
  logic [LEN_W-1:0]   r_len;
  logic [BYTE_W-1:0]  r_len_lo;

  logic               w_hs;
  logic               w_start_ok;
  logic [LEN_W-1:0]   w_len_word;
  logic               w_len_bad;
  logic               w_word_ready;
  logic [WORD_W-1:0]  w_word;

  assign w_hs       = byte_valid && byte_ready;
  assign w_start_ok = start && ((r_state == ST_IDLE) || (r_state == ST_DONE) ||
                                (r_state == ST_ERR));
  assign w_len_word = {byte_in, r_len_lo};
  assign w_len_bad  = (w_len_word == '0) ||
                      ({{(32-LEN_W){1'b0}}, w_len_word} > 32'(DEPTH_WORDS));

  byte_packer u_packer (
    .clk          (clk),
    .reset        (reset),
    .i_clear      (w_start_ok),
    .i_byte_en    (w_hs && (r_state == ST_DATA)),
    .i_byte       (byte_in),
    .o_word       (w_word),
    .o_word_ready (w_word_ready)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_idx    <= '0;
      r_len    <= '0;
      r_len_lo <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_start_ok) begin
        r_idx <= '0;
      end
      if (w_hs && (r_state == ST_LEN_LO)) begin
        r_len_lo <= byte_in;
      end
      if (w_hs && (r_state == ST_LEN_HI)) begin
        r_len <= w_len_word;
      end
      if (r_state == ST_WRITE) begin
        r_idx <= r_idx + 1'b1;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) w_state_next = ST_LEN_LO;
      end
      ST_LEN_LO: begin
        if (w_hs) w_state_next = ST_LEN_HI;
      end
      ST_LEN_HI: begin
        if (w_hs) w_state_next = w_len_bad ? ST_ERR : ST_DATA;
      end
      ST_DATA: begin
        if (w_word_ready) w_state_next = ST_WRITE;
      end
      ST_WRITE: begin
        w_state_next = ((r_idx + 1'b1) == r_len) ? ST_DONE : ST_DATA;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  assign byte_ready = (r_state == ST_LEN_LO) || (r_state == ST_LEN_HI) ||
                      (r_state == ST_DATA);
  assign imem_we    = (r_state == ST_WRITE);
  assign imem_addr  = BASE_ADDR + {{(WORD_W-LEN_W-2){1'b0}}, r_idx, 2'b00};
  assign imem_wdata = w_word;
  assign cpu_reset  = (r_state != ST_DONE);
  assign busy       = byte_ready || (r_state == ST_WRITE);
  assign done       = (r_state == ST_DONE);
  assign error      = (r_state == ST_ERR);

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter DEPTH_WORDS, default 64; instruction-memory capacity in 32-bit words.
REQ-002 Parameter BASE_ADDR, default 32'h0000_0000; byte address of the first loaded word.
REQ-003 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: start  input  1  one-cycle pulse; begins a load when the block is idle, done, or in error.
REQ-006 Port: byte_in  input  8  serial program byte.
REQ-007 Port: byte_valid  input  1  byte_in holds a valid byte.
REQ-008 Port: byte_ready  output  1  loader accepts a byte this cycle; transfer occurs when byte_valid and byte_ready are both high.
REQ-009 Port: imem_we  output  1  instruction-memory write strobe, one cycle per word.
REQ-010 Port: imem_addr  output  32  word-aligned byte address for the write.
REQ-011 Port: imem_wdata  output  32  instruction word for the write.
REQ-012 Port: cpu_reset  output  1  holds the processor in reset while high.
REQ-013 Port: busy  output  1  load in progress.
REQ-014 Port: done  output  1  last load completed successfully.
REQ-015 Port: error  output  1  last load was rejected.

Function
REQ-016 States: IDLE, LEN_LO, LEN_HI, DATA, WRITE, DONE, ERR.
REQ-017 IDLE/DONE/ERR + start -> LEN_LO; word index and byte counter cleared.
REQ-018 start is ignored in LEN_LO, LEN_HI, DATA, and WRITE.
REQ-019 byte_ready is 1 only in LEN_LO, LEN_HI, and DATA; otherwise 0.
REQ-020 Frame format: 16-bit word count N, little-endian (LEN_LO byte, then LEN_HI byte), followed by N*4 payload bytes.
REQ-021 LEN_HI accept: if N == 0 or N > DEPTH_WORDS -> ERR; else -> DATA.
REQ-022 DATA packs bytes little-endian: the first byte goes to wdata[7:0] and the fourth byte to wdata[31:24].
REQ-023 The fourth accepted byte moves the FSM to WRITE.
REQ-024 Word assembly has no timeout; byte_valid gaps of any length stall the FSM.
REQ-025 WRITE lasts exactly 1 cycle, with imem_we=1, imem_addr=BASE_ADDR+4*idx, and imem_wdata=the assembled word.
REQ-026 Latency from the fourth byte's handshake edge to imem_we high is 1 cycle.
REQ-027 WRITE exit: idx incremented; if idx+1 == N -> DONE, else -> DATA.
REQ-028 imem_addr is computed modulo 2^32; no wrap occurs within DEPTH_WORDS.
REQ-029 imem_we is 0 in every state other than WRITE.
REQ-030 cpu_reset = 0 only in DONE; 1 in all other states.
REQ-031 busy = 1 in LEN_LO, LEN_HI, DATA, and WRITE.
REQ-032 done = 1 only in DONE; error = 1 only in ERR.
REQ-033 A start pulse in DONE re-asserts cpu_reset on the next cycle and begins a new load.
REQ-034 Bytes presented outside LEN_LO, LEN_HI, and DATA are not consumed, since byte_ready is 0.

Reset
REQ-035 reset sampled high on a clock edge -> state IDLE, idx=0, byte counter=0, word register=0.
REQ-036 Outputs after reset: cpu_reset=1, byte_ready=0, imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0, busy=0, done=0, error=0.
REQ-037 reset takes priority over start and over the byte handshake.
REQ-038 reset asserted mid-load abandons the load; no further imem_we is issued.

Structure
REQ-039 Shared package imem_loader_pkg holds the state enum, the byte/word/length width constants, and the default DEPTH_WORDS.
REQ-040 Sub-module byte_packer (2-bit byte counter, 32-bit shift/pack register, word_ready flag) performs word assembly.
REQ-041 The FSM, index counter, and output decode reside in imem_loader.

Verification
REQ-042 Basic load: start; bytes 02 00, 13 00 00 00, 93 00 10 00 -> writes 0x00000013 at addr 0x0 and 0x00100093 at addr 0x4; then done=1, cpu_reset=0.
REQ-043 Zero length: start; bytes 00 00 -> error=1, cpu_reset=1, no imem_we.
REQ-044 Oversize length: DEPTH_WORDS=64; length 41 00 (N=65) -> ERR; a following start plus a valid 1-word frame -> DONE.
REQ-045 Stalls: byte_valid toggled randomly during a 3-word frame -> exactly 3 imem_we pulses, each 1 cycle, with correct data and addresses 0x0, 0x4, 0x8.
REQ-046 Mid-load reset: reset asserted after 6 payload bytes -> next cycle IDLE, cpu_reset=1, only 1 write issued; a fresh load afterwards succeeds.
REQ-047 Reload: start in DONE -> cpu_reset=1 and busy=1 next cycle; a second frame overwrites from BASE_ADDR.
